// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and execute, remembering who
// owns each in-flight request so responses route back in order.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_req_addr,
   output logic        if_resp_valid,
   input  logic        if_resp_ready,
   output logic [31:0] if_resp_data,
   input  logic        ex_req_valid,
   output logic        ex_req_ready,
   input  logic [31:0] ex_req_addr,
   input  logic        ex_req_we,
   input  logic [31:0] ex_req_wdata,
   input  logic [3:0]  ex_req_be,
   output logic        ex_resp_valid,
   input  logic        ex_resp_ready,
   output logic [31:0] ex_resp_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready,
   input  logic [31:0] mem_resp_data
);
   localparam int   PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int   CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int   STV_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_EX = 1'b1;

   logic             q_owner [MAX_OUTSTANDING];
   logic             q_disc  [MAX_OUTSTANDING];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             lock_valid, lock_owner;
   logic [STV_W-1:0] starve_cnt;

   logic             full, empty, sel_ex, sel_valid, req_hs, resp_hs;
   logic             head_owner, head_disc;
   logic             lock_valid_nxt, lock_owner_nxt;
   logic [STV_W-1:0] starve_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      full  = (count == CNT_W'(MAX_OUTSTANDING));
      empty = (count == '0);

      // A held lock overrides the priority/starvation choice
      if (lock_valid)
         sel_ex = lock_owner;
      else
         sel_ex = ex_req_valid && !(if_req_valid && starve_cnt == STV_W'(STARVE_LIMIT));

      sel_valid     = sel_ex ? ex_req_valid : if_req_valid;
      mem_req_valid = rst && sel_valid && !full;
      if_req_ready  = rst && !sel_ex && mem_req_ready && !full;
      ex_req_ready  = rst && sel_ex && mem_req_ready && !full;
      mem_req_addr  = sel_ex ? ex_req_addr : if_req_addr;
      mem_req_we    = sel_ex && ex_req_we;
      mem_req_wdata = sel_ex ? ex_req_wdata : '0;
      mem_req_be    = sel_ex ? ex_req_be : 4'hF;
      req_hs        = mem_req_valid && mem_req_ready;

      head_owner     = q_owner[rd_ptr];
      head_disc      = q_disc[rd_ptr];
      mem_resp_ready = 1'b0;
      if_resp_valid  = 1'b0;
      ex_resp_valid  = 1'b0;
      if (rst && !empty) begin
         if (head_disc) begin
            mem_resp_ready = 1'b1;
         end else if (head_owner == OWN_EX) begin
            ex_resp_valid  = mem_resp_valid;
            mem_resp_ready = ex_resp_ready;
         end else begin
            if_resp_valid  = mem_resp_valid;
            mem_resp_ready = if_resp_ready;
         end
      end
      if_resp_data = mem_resp_data;
      ex_resp_data = mem_resp_data;
      resp_hs      = mem_resp_valid && mem_resp_ready;

      lock_valid_nxt = lock_valid;
      lock_owner_nxt = lock_owner;
      if (req_hs) begin
         lock_valid_nxt = 1'b0;
      end else if (mem_req_valid) begin
         lock_valid_nxt = 1'b1;
         lock_owner_nxt = sel_ex;
      end
      if (flush && lock_owner_nxt == OWN_IF)
         lock_valid_nxt = 1'b0;

      starve_nxt = starve_cnt;
      if (flush || !if_req_valid || (req_hs && !sel_ex))
         starve_nxt = '0;
      else if (req_hs && starve_cnt != STV_W'(STARVE_LIMIT))
         starve_nxt = starve_cnt + STV_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         lock_valid <= 1'b0;
         lock_owner <= OWN_IF;
         starve_cnt <= '0;
      end else begin
         lock_valid <= lock_valid_nxt;
         lock_owner <= lock_owner_nxt;
         starve_cnt <= starve_nxt;
         if (req_hs)  wr_ptr <= ptr_inc(wr_ptr);
         if (resp_hs) rd_ptr <= ptr_inc(rd_ptr);
         case ({req_hs, resp_hs})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry contents are only meaningful while counted, so they carry no reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++)
         if (flush && q_owner[i] == OWN_IF) q_disc[i] <= 1'b1;
      if (req_hs) begin
         q_owner[wr_ptr] <= sel_ex;
         q_disc[wr_ptr]  <= flush && !sel_ex;
      end
   end

   resp_while_empty: assert property (@(posedge clk) disable iff (!rst) !(mem_resp_valid && empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives the memory side by hand and
// checks grants, locking, routing, flush discard and reset.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst, flush;
   logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
   logic [31:0] if_req_addr, if_resp_data;
   logic        ex_req_valid, ex_req_ready, ex_req_we, ex_resp_valid, ex_resp_ready;
   logic [31:0] ex_req_addr, ex_req_wdata, ex_resp_data;
   logic [3:0]  ex_req_be;
   logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
   logic [3:0]  mem_req_be;

   int          checks = 0;
   int          errors = 0;
   logic [5:0]  grant_ex = 6'b101111;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
      .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready), .ex_req_addr(ex_req_addr),
      .ex_req_we(ex_req_we), .ex_req_wdata(ex_req_wdata), .ex_req_be(ex_req_be),
      .ex_resp_valid(ex_resp_valid), .ex_resp_ready(ex_resp_ready), .ex_resp_data(ex_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0;
      if_req_valid = 0; if_req_addr = '0; if_resp_ready = 1;
      ex_req_valid = 0; ex_req_addr = '0; ex_req_we = 0; ex_req_wdata = '0; ex_req_be = 4'h0;
      ex_resp_ready = 1;
      mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = '0;
   endtask

   initial begin
      rst = 0;
      idle();
      if_req_valid = 1; if_req_addr = 32'h100;
      ex_req_valid = 1; ex_req_addr = 32'h200;
      tick(); tick();
      #1;
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_if_req_ready", if_req_ready, 0);
      chk("rst_ex_req_ready", ex_req_ready, 0);
      chk("rst_mem_resp_ready", mem_resp_ready, 0);
      chk("rst_resp_valids", {if_resp_valid, ex_resp_valid}, 0);
      tick();
      rst = 1;
      idle();

      // IF-only stream with one-cycle response latency
      if_req_valid = 1; if_req_addr = 32'h100;
      #1;
      chk("ifs_valid0", mem_req_valid, 1);
      chk("ifs_addr0", mem_req_addr, 32'h100);
      chk("ifs_ready0", if_req_ready, 1);
      chk("ifs_be0", {mem_req_we, mem_req_be}, 5'h0F);
      tick();
      if_req_addr = 32'h104; mem_resp_valid = 1; mem_resp_data = 32'h11;
      #1;
      chk("ifs_addr1", mem_req_addr, 32'h104);
      chk("ifs_ready1", if_req_ready, 1);
      chk("ifs_resp_valid1", if_resp_valid, 1);
      chk("ifs_resp_data1", if_resp_data, 32'h11);
      chk("ifs_mem_resp_ready1", mem_resp_ready, 1);
      tick();
      if_req_addr = 32'h108; mem_resp_data = 32'h22;
      #1;
      chk("ifs_addr2", mem_req_addr, 32'h108);
      chk("ifs_resp_data2", if_resp_data, 32'h22);
      chk("ifs_resp_valid2", if_resp_valid, 1);
      tick();
      if_req_valid = 0; mem_resp_data = 32'h33;
      #1;
      chk("ifs_req_off", mem_req_valid, 0);
      chk("ifs_resp_valid3", if_resp_valid, 1);
      chk("ifs_resp_data3", if_resp_data, 32'h33);
      tick();
      mem_resp_valid = 0;
      #1;
      chk("ifs_empty_resp_ready", mem_resp_ready, 0);

      // Both requesters valid every cycle: EX x4, then IF, then EX
      for (int i = 0; i < 6; i++) begin
         if_req_valid = 1; if_req_addr = 32'h300;
         ex_req_valid = 1; ex_req_addr = 32'h200;
         mem_resp_valid = (i > 0); mem_resp_data = i;
         #1;
         chk($sformatf("grant_addr%0d", i), mem_req_addr, grant_ex[i] ? 32'h200 : 32'h300);
         chk($sformatf("grant_ex_ready%0d", i), ex_req_ready, grant_ex[i]);
         chk($sformatf("grant_if_ready%0d", i), if_req_ready, !grant_ex[i]);
         if (i > 0) begin
            chk($sformatf("route_ex%0d", i), ex_resp_valid, grant_ex[i-1]);
            chk($sformatf("route_if%0d", i), if_resp_valid, !grant_ex[i-1]);
         end
         tick();
      end
      if_req_valid = 0; ex_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h6;
      #1;
      chk("grant_tail_ex_valid", ex_resp_valid, 1);
      chk("grant_tail_ex_data", ex_resp_data, 32'h6);
      tick();
      idle();

      // EX stalls on mem_req_ready = 0; IF arrives meanwhile
      ex_req_valid = 1; ex_req_addr = 32'h400; mem_req_ready = 0;
      #1;
      chk("lock_c1_valid", mem_req_valid, 1);
      chk("lock_c1_addr", mem_req_addr, 32'h400);
      chk("lock_c1_ex_ready", ex_req_ready, 0);
      tick();
      if_req_valid = 1; if_req_addr = 32'h500;
      #1;
      chk("lock_c2_addr", mem_req_addr, 32'h400);
      chk("lock_c2_if_ready", if_req_ready, 0);
      tick();
      #1;
      chk("lock_c3_addr", mem_req_addr, 32'h400);
      tick();
      mem_req_ready = 1;
      #1;
      chk("lock_c4_ex_ready", ex_req_ready, 1);
      chk("lock_c4_addr", mem_req_addr, 32'h400);
      tick();
      ex_req_valid = 0;
      #1;
      chk("lock_c5_if_ready", if_req_ready, 1);
      chk("lock_c5_addr", mem_req_addr, 32'h500);
      tick();

      // Queue now holds EX, IF: a new EX request must wait for a pop
      if_req_valid = 0; ex_req_valid = 1; ex_req_addr = 32'h404;
      #1;
      chk("full_ex_ready", ex_req_ready, 0);
      chk("full_mem_valid", mem_req_valid, 0);
      tick();
      mem_resp_valid = 1; mem_resp_data = 32'hAA;
      #1;
      chk("full_pop_ex_resp", ex_resp_valid, 1);
      chk("full_pop_ex_ready", ex_req_ready, 0);
      tick();
      mem_resp_data = 32'hBB;
      #1;
      chk("full_resume_ex_ready", ex_req_ready, 1);
      chk("full_resume_addr", mem_req_addr, 32'h404);
      chk("full_if_resp_valid", if_resp_valid, 1);
      chk("full_if_resp_data", if_resp_data, 32'hBB);
      tick();
      ex_req_valid = 0; mem_resp_data = 32'hCC;
      #1;
      chk("full_last_ex_resp", ex_resp_valid, 1);
      chk("full_last_ex_data", ex_resp_data, 32'hCC);
      tick();
      idle();

      // Flush discards two outstanding IF responses
      if_req_valid = 1; if_req_addr = 32'h600;
      tick();
      if_req_addr = 32'h604;
      tick();
      if_req_valid = 0; flush = 1;
      tick();
      flush = 0; if_resp_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hAAAA;
      #1;
      chk("flush_d1_mem_resp_ready", mem_resp_ready, 1);
      chk("flush_d1_if_resp_valid", if_resp_valid, 0);
      tick();
      ex_req_valid = 1; ex_req_addr = 32'h700; mem_resp_data = 32'hBBBB;
      #1;
      chk("flush_d2_mem_resp_ready", mem_resp_ready, 1);
      chk("flush_d2_if_resp_valid", if_resp_valid, 0);
      chk("flush_ex_ready", ex_req_ready, 1);
      tick();
      ex_req_valid = 0; mem_resp_data = 32'hDEADBEEF;
      #1;
      chk("flush_ex_resp_valid", ex_resp_valid, 1);
      chk("flush_ex_resp_data", ex_resp_data, 32'hDEADBEEF);
      chk("flush_if_quiet", if_resp_valid, 0);
      tick();
      idle();

      // IF lock is released by flush; EX then wins
      if_req_valid = 1; if_req_addr = 32'h800; mem_req_ready = 0;
      tick();
      ex_req_valid = 1; ex_req_addr = 32'h900;
      #1;
      chk("iflock_addr", mem_req_addr, 32'h800);
      chk("iflock_ex_ready", ex_req_ready, 0);
      tick();
      flush = 1;
      tick();
      flush = 0; mem_req_ready = 1;
      #1;
      chk("iflock_release_addr", mem_req_addr, 32'h900);
      chk("iflock_release_ex_ready", ex_req_ready, 1);
      tick();
      if_req_valid = 0; ex_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h55;
      #1;
      chk("iflock_ex_resp", ex_resp_valid, 1);
      tick();
      idle();

      // Store with partial byte enables, then reset mid-flight
      ex_req_valid = 1; ex_req_addr = 32'h1000; ex_req_we = 1;
      ex_req_wdata = 32'hCAFEF00D; ex_req_be = 4'b0011;
      #1;
      chk("st_addr", mem_req_addr, 32'h1000);
      chk("st_we", mem_req_we, 1);
      chk("st_wdata", mem_req_wdata, 32'hCAFEF00D);
      chk("st_be", mem_req_be, 32'h3);
      chk("st_ready", ex_req_ready, 1);
      tick();
      idle();
      rst = 0;
      #1;
      chk("st_rst_valids", {mem_req_valid, if_resp_valid, ex_resp_valid}, 0);
      chk("st_rst_readies", {if_req_ready, ex_req_ready, mem_resp_ready}, 0);
      tick();
      rst = 1;
      #1;
      chk("st_post_empty", mem_resp_ready, 0);
      if_req_valid = 1; if_req_addr = 32'h2000;
      #1;
      chk("st_post_if_ready", if_req_ready, 1);
      tick();
      if_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h77;
      #1;
      chk("st_post_if_resp", if_resp_valid, 1);
      chk("st_post_ex_quiet", ex_resp_valid, 0);
      chk("st_post_data", if_resp_data, 32'h77);
      tick();
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF) and the execute-stage memory unit (EX).
- Issues at most one request per cycle and tracks in-flight requests in an in-order owner queue.
- Routes each memory response back to the requester that issued it.
- On pipeline flush, drops responses still owed to fetch so that stale instruction words never reach the front end.

Parameters:
MAX_OUTSTANDING, 2, owner-queue depth; maximum number of requests in flight on the memory port (power of 2, at least 1)
STARVE_LIMIT, 4, consecutive EX grants allowed while IF is waiting before IF is forced to win

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
flush  in  1  pipeline flush; discards outstanding IF responses
if_req_valid  in  1  fetch request valid
if_req_ready  out  1  fetch request accepted
if_req_addr  in  32  fetch address
if_resp_valid  out  1  fetch response valid
if_resp_ready  in  1  fetch response consumed
if_resp_data  out  32  fetched word
ex_req_valid  in  1  execute request valid
ex_req_ready  out  1  execute request accepted
ex_req_addr  in  32  load/store address
ex_req_we  in  1  1 = store
ex_req_wdata  in  32  store data
ex_req_be  in  4  byte enables
ex_resp_valid  out  1  execute response valid
ex_resp_ready  in  1  execute response consumed
ex_resp_data  out  32  load data; don't-care for stores
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepted request
mem_req_addr  out  32  request address
mem_req_we  out  1  request write enable (0 for IF)
mem_req_wdata  out  32  write data (0 for IF)
mem_req_be  out  4  byte enables (4'hF for IF)
mem_resp_valid  in  1  memory response valid
mem_resp_ready  out  1  response consumed
mem_resp_data  in  32  response data

Behaviour:
- Reset (rst == 0 at a clk edge):
  - Owner queue empty, lock cleared, starve counter = 0.
  - All *_valid and *_ready outputs are 0 while in reset.
- Memory contract: exactly one response per accepted request, including stores. Responses return in issue order.
- Issue is combinational pass-through with zero added latency:
  - mem_req_valid = selected requester's valid AND queue not full.
  - The winner's *_req_ready = mem_req_ready AND queue not full. The loser's ready = 0.
  - Full is computed from the registered count only; a same-cycle pop does not free a slot.
- Selection when no lock is held:
  - EX wins when ex_req_valid, unless IF is valid and starve_cnt == STARVE_LIMIT.
  - Otherwise IF wins.
- Lock:
  - If mem_req_valid is 1 and mem_req_ready is 0, the current winner is registered as a lock.
  - The locked requester's fields drive the port until the handshake completes.
  - The lock clears on the handshake.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on each EX handshake while if_req_valid is 1.
  - Clears on any IF handshake, and clears when IF is not valid.
- Owner queue:
  - Entry = {owner (0 = IF, 1 = EX), discard}.
  - Push on mem_req handshake; pop on mem_resp handshake.
  - Push and pop in the same cycle leave the count unchanged.
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Response routing (head entry):
  - Owner IF, not discard: if_resp_valid = mem_resp_valid; mem_resp_ready = if_resp_ready.
  - Owner EX: ex_resp_valid = mem_resp_valid; mem_resp_ready = ex_resp_ready.
  - Discard set: mem_resp_ready = 1 and no *_resp_valid is raised (the response is silently consumed).
  - Empty queue: mem_resp_ready = 0. mem_resp_valid while the queue is empty is a protocol error, flagged by an assertion.
  - resp_data is forwarded combinationally.
- Flush (flush == 1 in a cycle):
  - Every IF entry in the queue gets discard = 1.
  - An IF push in the same cycle is pushed with discard = 1.
  - An IF response handshaking in that cycle is still delivered.
  - A held IF lock is released, and the starve counter clears.
  - EX entries and an EX lock are unaffected.
- Reset asserted mid-operation abandons all in-flight state. Memory must be reset concurrently.

Test Plan:
- IF-only stream, mem_req_ready = 1, responses 1 cycle later → back-to-back issue, 2 in flight, if_resp_data in order 0x11, 0x22, 0x33.
- IF and EX both valid every cycle, STARVE_LIMIT = 4 → grant sequence EX, EX, EX, EX, IF, EX...
- EX wins with mem_req_ready = 0 for 3 cycles; IF raised meanwhile → address held at EX value; lock holds through cycle 3; IF issues afterwards.
- Two IF requests outstanding, flush pulsed → both responses consumed with mem_resp_ready = 1, if_resp_valid stays 0; a following EX load returns 0xDEADBEEF on ex_resp.
- Queue full (2 outstanding) while ex_req_valid = 1 → ex_req_ready = 0 until a pop; issue resumes the cycle after the pop.
- Store with be = 4'b0011, followed by rst = 0 for 1 cycle mid-flight → store is issued with matching fields; after reset all valids = 0 and the queue is empty.
